// File: rtl/ssd_scan_if.sv
// Bundle between the display controller and the seven-segment scan driver.
// The blink input exists only when SSD_BLINK_EN is defined.
interface ssd_scan_if;
  logic [31:0] display;
  logic        load;
  logic        enable;
`ifdef SSD_BLINK_EN
  logic        blink;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  logic        pending;

  modport master (
`ifdef SSD_BLINK_EN
    output blink,
`endif
    output display, load, enable,
    input  an, seg, dp, frame_start, pending
  );

  modport slave (
`ifdef SSD_BLINK_EN
    input  blink,
`endif
    input  display, load, enable,
    output an, seg, dp, frame_start, pending
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a frame-synchronous double buffer.
// Optional blink support is enabled by defining SSD_BLINK_EN.
module ssd_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic       clk,
  input logic       rst,
  ssd_scan_if.slave bus
);

  localparam int             CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [0:0]     PH_BLANK  = 1'b0;
  localparam logic [0:0]     PH_DRIVE  = 1'b1;
  // Without a blanking gap the first slot must not open with a stray blank cycle.
  localparam logic [0:0]     PH_RESET  = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    digit;
  logic [0:0]    phase;
  logic [31:0]   shadow;
  logic [31:0]   active;
  logic          pending;
  logic          slot_wrap;
  logic          frame_wrap;
  logic [7:0]    cur_byte;
  logic          drive;
  logic          lit;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_start_q;

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (digit == 2'd3);
  assign cnt_next   = slot_wrap ? '0 : cnt + 1'b1;
  assign cur_byte   = active[{digit, 3'b000} +: 8];
  assign drive      = (phase == PH_DRIVE) && bus.enable && lit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      digit <= 2'd0;
      phase <= PH_RESET;
    end else begin
      cnt   <= cnt_next;
      if (slot_wrap) digit <= digit + 2'd1;
      phase <= (cnt_next < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    end
  end

  // NOTE: shadow/active are ordinary 32-bit registers, not a memory array,
  // so resetting them costs nothing and discards stale frame data.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // A load on the wrap cycle still sets pending: the later assignment wins.
      if (bus.load) begin
        shadow  <= bus.display;
        pending <= 1'b1;
      end
    end
  end

`ifdef SSD_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst || !bus.blink) begin
      frame_cnt <= '0;
      lit       <= 1'b1;
    end else if (frame_start_q) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        lit       <= ~lit;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign lit = 1'b1;
`endif

  // Outputs are registered from the pre-edge scan state, so they trail cnt/digit by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= (cnt == '0) && (digit == 2'd0);
      if (drive) begin
        an_q  <= ~(4'b0001 << digit);
        seg_q <= ~cur_byte[6:0];
        dp_q  <= ~cur_byte[7];
      end else begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending;

endmodule
